// File: rtl/wb_initiator.sv
// wb_initiator: bridges a single-beat CPU load/store request onto a Wishbone classic
// bus. Checks alignment, steers byte lanes, extends read data and aborts a bus cycle
// that sees no acknowledge within TIMEOUT+1 cycles.
module wb_initiator #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  // CPU request side
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  // CPU response side
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  // Wishbone initiator
  output logic [31:0] wb_addr,
  output logic [31:0] wb_wdata,
  output logic [3:0]  wb_sel,
  output logic        wb_we,
  output logic        wb_cyc,
  output logic        wb_stb,
  input  logic [31:0] wb_rdata,
  input  logic        wb_ack
);

  // Counter only ever reaches TIMEOUT, so this width never wraps.
  localparam int unsigned    CntW   = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT);

  localparam logic [1:0] SzByte = 2'b00;
  localparam logic [1:0] SzHalf = 2'b01;
  localparam logic [1:0] SzWord = 2'b10;

  typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        sel_q, sel_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              signed_q, signed_d;
  logic [1:0]        lane_q, lane_d;
  logic              rsp_err_q, rsp_err_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;

  logic              misaligned;
  logic [3:0]        req_sel;
  logic [31:0]       req_wdata_rep;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [31:0]       rd_ext;

  // Decode the incoming request: alignment, lane enables and replicated write data.
  always_comb begin
    misaligned    = 1'b0;
    req_sel       = 4'b0000;
    req_wdata_rep = req_wdata;
    unique case (req_size)
      SzByte: begin
        req_sel       = 4'b0001 << req_addr[1:0];
        req_wdata_rep = {4{req_wdata[7:0]}};
      end
      SzHalf: begin
        misaligned    = req_addr[0];
        req_sel       = req_addr[1] ? 4'b1100 : 4'b0011;
        req_wdata_rep = {2{req_wdata[15:0]}};
      end
      SzWord: begin
        misaligned = |req_addr[1:0];
        req_sel    = 4'b1111;
      end
      default: misaligned = 1'b1;
    endcase
  end

  // Pick the addressed lane(s) out of the bus word and extend to 32 bits.
  always_comb begin
    rd_byte = wb_rdata[7:0];
    unique case (lane_q)
      2'd0: rd_byte = wb_rdata[7:0];
      2'd1: rd_byte = wb_rdata[15:8];
      2'd2: rd_byte = wb_rdata[23:16];
      2'd3: rd_byte = wb_rdata[31:24];
      default: rd_byte = wb_rdata[7:0];
    endcase
    rd_half = lane_q[1] ? wb_rdata[31:16] : wb_rdata[15:0];
    unique case (size_q)
      SzByte:  rd_ext = signed_q ? {{24{rd_byte[7]}}, rd_byte} : {24'h0, rd_byte};
      SzHalf:  rd_ext = signed_q ? {{16{rd_half[15]}}, rd_half} : {16'h0, rd_half};
      default: rd_ext = wb_rdata;
    endcase
  end

  // Next-state logic: IDLE accepts, BUS waits for ack or timeout, RESP strobes once.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    sel_d       = sel_q;
    we_d        = we_q;
    size_d      = size_q;
    signed_d    = signed_q;
    lane_d      = lane_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (misaligned) begin
            // Rejected without touching the bus.
            state_d     = StResp;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'h0;
          end else begin
            state_d  = StBus;
            cnt_d    = '0;
            addr_d   = {req_addr[31:2], 2'b00};
            wdata_d  = req_wdata_rep;
            sel_d    = req_sel;
            we_d     = req_we;
            size_d   = req_size;
            signed_d = req_signed;
            lane_d   = req_addr[1:0];
          end
        end
      end
      StBus: begin
        // Ack is checked first so an ack on the final counted cycle still succeeds.
        if (wb_ack) begin
          state_d     = StResp;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = we_q ? 32'h0 : rd_ext;
        end else if (cnt_q == CntMax) begin
          state_d     = StResp;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = 32'h0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers, all cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      sel_q       <= 4'h0;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      signed_q    <= 1'b0;
      lane_q      <= 2'b00;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      sel_q       <= sel_d;
      we_q        <= we_d;
      size_q      <= size_d;
      signed_q    <= signed_d;
      lane_q      <= lane_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Handshake and strobes come straight from the state register, so reset drops them at once.
  assign req_ready = (state_q == StIdle);
  assign wb_cyc    = (state_q == StBus);
  assign wb_stb    = (state_q == StBus);
  assign rsp_valid = (state_q == StResp);
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign wb_addr   = addr_q;
  assign wb_wdata  = wdata_q;
  assign wb_sel    = sel_q;
  assign wb_we     = we_q;

endmodule

// File: tb/tb_wb_initiator.sv
// tb_wb_initiator: drives directed and random requests into wb_initiator (TIMEOUT=4)
// with a scripted Wishbone responder and compares against an arithmetic reference model.
module tb_wb_initiator;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] wb_addr, wb_wdata, wb_rdata;
  logic [3:0]  wb_sel;
  logic        wb_we, wb_cyc, wb_stb, wb_ack;

  int n_checks = 0;
  int n_pass   = 0;

  // Observations of the most recent transaction
  int          obs_stb, obs_first_stb, obs_rsp_cnt, obs_rsp_i;
  logic        obs_err, obs_we, obs_stable, obs_ready_req, obs_ready_after;
  logic [31:0] obs_rdata, obs_addr, obs_wdata;
  logic [3:0]  obs_sel;

  // Model outputs
  logic        exp_mis, exp_err;
  logic [3:0]  exp_sel;
  logic [31:0] exp_wdata, exp_rdata, exp_addr;
  int          exp_stb, exp_rsp_i;

  wb_initiator #(.TIMEOUT(T)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .wb_addr    (wb_addr),
    .wb_wdata   (wb_wdata),
    .wb_sel     (wb_sel),
    .wb_we      (wb_we),
    .wb_cyc     (wb_cyc),
    .wb_stb     (wb_stb),
    .wb_rdata   (wb_rdata),
    .wb_ack     (wb_ack)
  );

  always #5 clk = ~clk;

  // Reference: what a request should produce, from the size/alignment rules.
  // ack_at is the strobe cycle (1-based) on which the responder acks; 0 = never.
  function automatic void model(input logic [31:0] a, input logic [31:0] wd, input logic we,
                                input logic [1:0] sz, input logic sg, input logic [31:0] rd,
                                input int ack_at);
    int unsigned nbytes = 1 << sz;
    int unsigned off    = a % 4;
    longint      v;
    logic        tmo;
    exp_mis   = (sz == 2'd3) || (a % nbytes != 0);
    exp_sel   = 4'(((1 << nbytes) - 1) << off);
    exp_addr  = a - off;
    exp_wdata = (nbytes == 1) ? 32'(wd % 256) * 32'h0101_0101 :
                (nbytes == 2) ? 32'(wd % 65536) * 32'h0001_0001 : wd;
    tmo       = (ack_at == 0) || (ack_at > T + 1);
    v = longint'(rd >> (8 * off)) & ((64'sd1 << (8 * nbytes)) - 1);
    if (sg && (((v >> (8 * nbytes - 1)) & 1) == 1)) v = v - (64'sd1 << (8 * nbytes));
    if (exp_mis) begin
      exp_err = 1'b1; exp_rdata = 32'h0; exp_stb = 0; exp_rsp_i = 1;
    end else if (tmo) begin
      exp_err = 1'b1; exp_rdata = 32'h0; exp_stb = T + 1; exp_rsp_i = T + 2;
    end else begin
      exp_err = 1'b0; exp_rdata = we ? 32'h0 : v[31:0]; exp_stb = ack_at; exp_rsp_i = ack_at + 1;
    end
  endfunction

  // Issue one request, play responder, record what the DUT did (bounded to 40 cycles).
  task automatic run_txn(input logic [31:0] a, input logic [31:0] wd, input logic we,
                         input logic [1:0] sz, input logic sg, input logic [31:0] rd,
                         input int ack_at);
    obs_stb = 0; obs_first_stb = 0; obs_rsp_cnt = 0; obs_rsp_i = 0; obs_stable = 1'b1;
    obs_err = 1'b0; obs_rdata = 32'h0; obs_ready_after = 1'b0;
    obs_sel = 4'h0; obs_addr = 32'h0; obs_wdata = 32'h0; obs_we = 1'b0;
    @(negedge clk);
    obs_ready_req = req_ready;
    req_valid = 1'b1; req_addr = a; req_wdata = wd; req_we = we; req_size = sz;
    req_signed = sg;
    @(posedge clk);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
      wb_ack    = 1'b0;
      wb_rdata  = $urandom;
      if (wb_cyc !== wb_stb) obs_stable = 1'b0;
      if (wb_stb === 1'b1) begin
        obs_stb++;
        if (obs_stb == 1) begin
          obs_first_stb = i; obs_sel = wb_sel; obs_addr = wb_addr; obs_wdata = wb_wdata;
          obs_we = wb_we;
        end else if ({wb_sel, wb_addr, wb_wdata, wb_we} !== {obs_sel, obs_addr, obs_wdata, obs_we}) begin
          obs_stable = 1'b0;
        end
        if (obs_stb == ack_at) begin
          wb_ack = 1'b1; wb_rdata = rd;
        end
      end
      if (rsp_valid === 1'b1) begin
        obs_rsp_cnt++;
        if (obs_rsp_cnt == 1) begin
          obs_rsp_i = i; obs_err = rsp_err; obs_rdata = rsp_rdata;
        end
      end
      if (obs_rsp_i != 0 && i == obs_rsp_i + 1) begin
        obs_ready_after = req_ready;
        break;
      end
    end
    wb_ack = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; req_valid = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_we = 1'b0;
    req_size = 2'b00; req_signed = 1'b0; wb_rdata = 32'h0; wb_ack = 1'b0;
    #1;
    n_checks++; if ({wb_cyc, wb_stb, rsp_valid} !== 3'b000) $display("FAIL reset_strobes got %b want 000", {wb_cyc, wb_stb, rsp_valid}); else n_pass++;
    n_checks++; if ({wb_addr, wb_wdata} !== 64'h0) $display("FAIL reset_addr_data got %h want 0", {wb_addr, wb_wdata}); else n_pass++;
    n_checks++; if ({wb_sel, wb_we, rsp_err} !== 6'h0) $display("FAIL reset_sel_we_err got %b want 0", {wb_sel, wb_we, rsp_err}); else n_pass++;
    n_checks++; if (rsp_rdata !== 32'h0) $display("FAIL reset_rdata got %h want 0", rsp_rdata); else n_pass++;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (req_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", req_ready); else n_pass++;
  endtask

  task automatic test_word_read;
    run_txn(32'h100, 32'h0, 1'b0, 2'b10, 1'b0, 32'hDEADBEEF, 2);
    n_checks++; if (obs_ready_req !== 1'b1) $display("FAIL word_ready got %b want 1", obs_ready_req); else n_pass++;
    n_checks++; if (obs_sel !== 4'b1111) $display("FAIL word_sel got %b want 1111", obs_sel); else n_pass++;
    n_checks++; if (obs_first_stb != 1) $display("FAIL word_stb_latency got %0d want 1", obs_first_stb); else n_pass++;
    n_checks++; if ({obs_err, obs_rdata} !== {1'b0, 32'hDEADBEEF}) $display("FAIL word_rsp got err=%b data=%h want err=0 data=deadbeef", obs_err, obs_rdata); else n_pass++;
    n_checks++; if (obs_rsp_cnt != 1 || obs_rsp_i != 3) $display("FAIL word_rsp_pulse got cnt=%0d at=%0d want cnt=1 at=3", obs_rsp_cnt, obs_rsp_i); else n_pass++;
    n_checks++; if (obs_ready_after !== 1'b1) $display("FAIL word_ready_after got %b want 1", obs_ready_after); else n_pass++;
  endtask

  task automatic test_byte_read;
    run_txn(32'h103, 32'h0, 1'b0, 2'b00, 1'b1, 32'h80112233, 1);
    n_checks++; if (obs_sel !== 4'b1000) $display("FAIL byte_sel got %b want 1000", obs_sel); else n_pass++;
    n_checks++; if (obs_rdata !== 32'hFFFFFF80) $display("FAIL byte_signed got %h want ffffff80", obs_rdata); else n_pass++;
    run_txn(32'h103, 32'h0, 1'b0, 2'b00, 1'b0, 32'h80112233, 3);
    n_checks++; if (obs_rdata !== 32'h00000080) $display("FAIL byte_unsigned got %h want 00000080", obs_rdata); else n_pass++;
  endtask

  task automatic test_half_write;
    run_txn(32'h202, 32'h0000ABCD, 1'b1, 2'b01, 1'b0, 32'h12345678, 2);
    n_checks++; if (obs_addr !== 32'h200) $display("FAIL half_addr got %h want 200", obs_addr); else n_pass++;
    n_checks++; if ({obs_sel, obs_we} !== {4'b1100, 1'b1}) $display("FAIL half_sel_we got %b want 11001", {obs_sel, obs_we}); else n_pass++;
    n_checks++; if (obs_wdata !== 32'hABCDABCD) $display("FAIL half_wdata got %h want abcdabcd", obs_wdata); else n_pass++;
    n_checks++; if ({obs_err, obs_rdata} !== 33'h0) $display("FAIL half_rsp got err=%b data=%h want 0/0", obs_err, obs_rdata); else n_pass++;
    n_checks++; if (!obs_stable) $display("FAIL half_stable got unstable want stable"); else n_pass++;
  endtask

  task automatic test_misaligned;
    logic [1:0] sizes [2] = '{2'b10, 2'b11};
    foreach (sizes[k]) begin
      run_txn(32'h101, 32'h0, 1'b0, sizes[k], 1'b0, 32'h0, 1);
      n_checks++; if (obs_stb != 0) $display("FAIL mis_nobus size=%b got %0d stb cycles want 0", sizes[k], obs_stb); else n_pass++;
      n_checks++; if (obs_rsp_i != 1 || obs_err !== 1'b1) $display("FAIL mis_rsp size=%b got at=%0d err=%b want at=1 err=1", sizes[k], obs_rsp_i, obs_err); else n_pass++;
    end
  endtask

  task automatic test_timeout;
    run_txn(32'h40, 32'h0, 1'b0, 2'b10, 1'b0, 32'h55AA55AA, 0);
    n_checks++; if (obs_stb != T + 1) $display("FAIL tmo_stb got %0d want %0d", obs_stb, T + 1); else n_pass++;
    n_checks++; if ({obs_err, obs_rdata} !== {1'b1, 32'h0}) $display("FAIL tmo_rsp got err=%b data=%h want 1/0", obs_err, obs_rdata); else n_pass++;
    n_checks++; if (obs_rsp_cnt != 1) $display("FAIL tmo_pulse got %0d want 1", obs_rsp_cnt); else n_pass++;
    run_txn(32'h40, 32'h0, 1'b0, 2'b10, 1'b0, 32'h55AA55AA, T + 1);
    n_checks++; if ({obs_err, obs_rdata} !== {1'b0, 32'h55AA55AA}) $display("FAIL ack_wins got err=%b data=%h want 0/55aa55aa", obs_err, obs_rdata); else n_pass++;
  endtask

  task automatic test_reset_mid_bus;
    int rsp_seen = 0;
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h80; req_we = 1'b0; req_size = 2'b10;
    @(negedge clk);
    req_valid = 1'b0;
    n_checks++; if (wb_cyc !== 1'b1) $display("FAIL rst_bus_start got cyc=%b want 1", wb_cyc); else n_pass++;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    n_checks++; if ({wb_cyc, wb_stb} !== 2'b00) $display("FAIL rst_async_drop got %b want 00", {wb_cyc, wb_stb}); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 1) wb_ack = 1'b1;
      if (rsp_valid !== 1'b0 || wb_cyc !== 1'b0 || req_ready !== 1'b1) rsp_seen++;
    end
    wb_ack = 1'b0;
    n_checks++; if (rsp_seen != 0) $display("FAIL rst_quiet got %0d bad cycles want 0", rsp_seen); else n_pass++;
    run_txn(32'h84, 32'h0, 1'b0, 2'b10, 1'b0, 32'hCAFEF00D, 1);
    n_checks++; if ({obs_err, obs_rdata} !== {1'b0, 32'hCAFEF00D}) $display("FAIL rst_recover got err=%b data=%h want 0/cafef00d", obs_err, obs_rdata); else n_pass++;
  endtask

  task automatic test_random;
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a  = $urandom;
      logic [31:0] wd = $urandom;
      logic [31:0] rd = $urandom;
      logic        we = 1'($urandom);
      logic        sg = 1'($urandom);
      logic [1:0]  sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      int          ak = $urandom_range(0, T + 3);
      if ($urandom_range(0, 1) == 1) a = a & ~((32'd1 << sz) - 1);
      model(a, wd, we, sz, sg, rd, ak);
      run_txn(a, wd, we, sz, sg, rd, ak);
      n_checks++; if (obs_rsp_cnt != 1 || obs_rsp_i != exp_rsp_i) $display("FAIL rnd_rsp_timing n=%0d got cnt=%0d at=%0d want 1 at=%0d", n, obs_rsp_cnt, obs_rsp_i, exp_rsp_i); else n_pass++;
      n_checks++; if ({obs_err, obs_rdata} !== {exp_err, exp_rdata}) $display("FAIL rnd_rsp n=%0d got err=%b data=%h want err=%b data=%h", n, obs_err, obs_rdata, exp_err, exp_rdata); else n_pass++;
      n_checks++; if (obs_stb != exp_stb) $display("FAIL rnd_stb n=%0d got %0d want %0d", n, obs_stb, exp_stb); else n_pass++;
      n_checks++; if (obs_ready_after !== 1'b1) $display("FAIL rnd_ready n=%0d got %b want 1", n, obs_ready_after); else n_pass++;
      if (!exp_mis) begin
        n_checks++; if ({obs_addr, obs_sel, obs_we} !== {exp_addr, exp_sel, we}) $display("FAIL rnd_bus n=%0d got %h/%b/%b want %h/%b/%b", n, obs_addr, obs_sel, obs_we, exp_addr, exp_sel, we); else n_pass++;
        n_checks++; if (obs_wdata !== exp_wdata) $display("FAIL rnd_wdata n=%0d got %h want %h", n, obs_wdata, exp_wdata); else n_pass++;
        n_checks++; if (!obs_stable) $display("FAIL rnd_stable n=%0d got unstable want stable", n); else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset;
    test_word_read;
    test_byte_read;
    test_half_write;
    test_misaligned;
    test_timeout;
    test_reset_mid_bus;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_initiator.md
WB_INITIATOR -- requirements
Module: wb_initiator

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the number of BUS-state cycles without wb_ack before abort (range 1..65535).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port req_valid, input, 1, CPU-side request present.
REQ-005 SHALL have port req_ready, output, 1, request accepted this cycle when high together with req_valid.
REQ-006 SHALL have port req_addr, input, 32, byte address.
REQ-007 SHALL have port req_wdata, input, 32, write data, right-aligned (byte in [7:0], half in [15:0]).
REQ-008 SHALL have port req_we, input, 1, 1 = write, 0 = read.
REQ-009 SHALL have port req_size, input, 2: 00 byte, 01 half, 10 word, 11 illegal.
REQ-010 SHALL have port req_signed, input, 1, sign-extend read data when 1, zero-extend when 0.
REQ-011 SHALL have port rsp_valid, output, 1, one-cycle response strobe.
REQ-012 SHALL have port rsp_rdata, output, 32, extended read data.
REQ-013 SHALL have port rsp_err, output, 1, misalignment, illegal size or timeout; qualified by rsp_valid.
REQ-014 SHALL have ports wb_addr (output, 32), wb_wdata (output, 32), wb_sel (output, 4), wb_we (output, 1), wb_cyc (output, 1), wb_stb (output, 1): Wishbone classic initiator outputs.
REQ-015 SHALL have ports wb_rdata (input, 32) and wb_ack (input, 1): Wishbone responder returns.

Function
REQ-016 SHALL implement a three-state FSM: IDLE, BUS, RESP.
REQ-017 SHALL drive req_ready = 1 only in IDLE; a handshake is req_valid & req_ready on a rising edge.
REQ-018 On handshake, SHALL flag misaligned when size=01 with addr[0]=1, size=10 with addr[1:0]≠00, or size=11; misaligned goes IDLE->RESP with rsp_err=1 and no bus cycle.
REQ-019 On an aligned handshake, SHALL latch all request fields and go IDLE->BUS; wb_cyc = wb_stb = 1 from the next cycle.
REQ-020 SHALL drive wb_addr = {req_addr[31:2], 2'b00}, wb_we = req_we, registered, stable throughout BUS.
REQ-021 SHALL generate wb_sel little-endian: byte -> 1 << addr[1:0]; half -> 0011 (addr[1]=0) or 1100 (addr[1]=1); word -> 1111; lane k is bits [8k+7:8k]; wb_sel is also valid for reads.
REQ-022 SHALL replicate write data across lanes: byte -> {4{wdata[7:0]}}, half -> {2{wdata[15:0]}}, word -> wdata.
REQ-023 In BUS, wb_ack=1 SHALL latch the extracted read data, deassert wb_cyc/wb_stb on the next cycle, and go to RESP with rsp_err=0.
REQ-024 Read extraction SHALL select the lane(s) given by addr[1:0] and size, then sign- or zero-extend per req_signed; for writes rsp_rdata SHALL be 0.
REQ-025 SHALL count BUS cycles from 0; when the count reaches TIMEOUT with no ack, SHALL deassert wb_cyc/wb_stb next cycle and go to RESP with rsp_err=1, rsp_rdata=0.
REQ-026 An ack on the same edge the count reaches TIMEOUT SHALL be treated as success (ack wins).
REQ-027 RESP SHALL assert rsp_valid for exactly one cycle, then return to IDLE; there is no back-pressure on the response.
REQ-028 wb_ack outside BUS SHALL be ignored and SHALL change no state.
REQ-029 Latency: handshake at edge N -> wb_stb high in cycle N+1; ack sampled at edge M -> rsp_valid in cycle M+1, req_ready in cycle M+2; misaligned -> rsp_valid in cycle N+1.
REQ-030 The timeout counter SHALL be cleared on entry to BUS and sized ceil(log2(TIMEOUT+1)) bits with no wrap-around.

Reset
REQ-031 reset=1 SHALL asynchronously force IDLE; req_ready=1 once reset is low; rsp_valid=0, rsp_err=0, rsp_rdata=0, wb_cyc=0, wb_stb=0, wb_we=0, wb_sel=0, wb_addr=0, wb_wdata=0; timeout counter 0.
REQ-032 Reset asserted mid-BUS SHALL drop wb_cyc/wb_stb immediately (same cycle) and emit no response.

Verification
REQ-033 Word read at 0x100, responder acks after 2 cycles with wb_rdata=0xDEADBEEF -> wb_sel=1111, rsp_rdata=0xDEADBEEF, rsp_err=0, one rsp_valid pulse.
REQ-034 Signed byte read at 0x103, wb_rdata=0x80112233 -> wb_sel=1000, rsp_rdata=0xFFFFFF80; the same read unsigned -> 0x00000080.
REQ-035 Half write at 0x202 with wdata 0x0000ABCD -> wb_addr=0x200, wb_sel=1100, wb_wdata=0xABCDABCD, wb_we=1, rsp_rdata=0.
REQ-036 Word read at 0x101 -> no wb_cyc, rsp_valid with rsp_err=1 one cycle after handshake; size=11 gives the same result.
REQ-037 TIMEOUT=4, no ack -> wb_stb high for exactly 5 cycles, then rsp_err=1; ack on the 5th cycle -> success.
REQ-038 reset pulsed while wb_cyc=1 -> wb_cyc=0 during the pulse, no rsp_valid, req_ready=1 after release; a stray wb_ack in IDLE has no effect.
